// File: rtl/mma_tile_scheduler.sv
// Walks an n x m x k matrix-multiply job in SIZE-sized tiles and issues one
// tile descriptor per cycle over a valid/ready handshake.
module mma_tile_scheduler #(
   parameter int unsigned SIZE      = 16,
   parameter int unsigned REG_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         cfg_16bits_ia,
   input  logic [REG_WIDTH-1:0]         n,
   input  logic [REG_WIDTH-1:0]         m,
   input  logic [REG_WIDTH-1:0]         k,
   input  logic [REG_WIDTH-1:0]         lhs_base,
   input  logic [REG_WIDTH-1:0]         rhs_base,
   input  logic [REG_WIDTH-1:0]         dst_base,
   input  logic [REG_WIDTH-1:0]         lhs_row_stride_b,
   input  logic [REG_WIDTH-1:0]         rhs_row_stride_b,
   input  logic [REG_WIDTH-1:0]         dst_row_stride_b,
   output logic                         tile_valid,
   input  logic                         tile_ready,
   output logic [REG_WIDTH-1:0]         tile_lhs_addr,
   output logic [REG_WIDTH-1:0]         tile_rhs_addr,
   output logic [REG_WIDTH-1:0]         tile_dst_addr,
   output logic [$clog2(SIZE):0]        tile_rows,
   output logic [$clog2(SIZE):0]        tile_cols,
   output logic [$clog2(SIZE):0]        tile_depth,
   output logic                         tile_k_first,
   output logic                         tile_k_last,
   output logic [REG_WIDTH-1:0]         tile_count,
   output logic                         busy,
   output logic                         done,
   output logic                         cfg_err
);

   localparam int unsigned RW    = REG_WIDTH;
   localparam int unsigned LOG2S = $clog2(SIZE);
   localparam int unsigned EXT_W = LOG2S + 1;
   localparam logic [RW-1:0] S_RW = RW'(SIZE);

   typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

   state_t state, state_d;

   // Remaining extents; the current tile is the last along a dimension when rem <= SIZE.
   logic [RW-1:0] n_rem, n_rem_d, m_rem, m_rem_d, k_rem, k_rem_d;
   logic [RW-1:0] m_cfg, m_cfg_d, k_cfg, k_cfg_d;
   // Per-tile address increments (stride * SIZE, SIZE * element size) precomputed at start.
   logic [RW-1:0] lhs_step, lhs_step_d, rhs_step, rhs_step_d, dst_step, dst_step_d;
   logic [RW-1:0] lhs_kstep, lhs_kstep_d, rhs_base_q, rhs_base_d;
   logic [RW-1:0] lhs_row, lhs_row_d, rhs_row, rhs_row_d, dst_row, dst_row_d;

   logic [RW-1:0]    lhs_addr_d, rhs_addr_d, dst_addr_d, count_d;
   logic [EXT_W-1:0] rows_d, cols_d, depth_d;
   logic             k_first_d, k_last_d, cfg_err_d;
   logic             k_end, m_end, n_end;

   function automatic logic [EXT_W-1:0] ext(input logic [RW-1:0] rem);
      if (rem >= S_RW) return EXT_W'(SIZE);
      return EXT_W'(rem);
   endfunction

   assign k_end = (k_rem <= S_RW);
   assign m_end = (m_rem <= S_RW);
   assign n_end = (n_rem <= S_RW);

   always_comb begin
      state_d     = state;
      n_rem_d     = n_rem;
      m_rem_d     = m_rem;
      k_rem_d     = k_rem;
      m_cfg_d     = m_cfg;
      k_cfg_d     = k_cfg;
      lhs_step_d  = lhs_step;
      rhs_step_d  = rhs_step;
      dst_step_d  = dst_step;
      lhs_kstep_d = lhs_kstep;
      rhs_base_d  = rhs_base_q;
      lhs_row_d   = lhs_row;
      rhs_row_d   = rhs_row;
      dst_row_d   = dst_row;
      lhs_addr_d  = tile_lhs_addr;
      rhs_addr_d  = tile_rhs_addr;
      dst_addr_d  = tile_dst_addr;
      rows_d      = tile_rows;
      cols_d      = tile_cols;
      depth_d     = tile_depth;
      k_first_d   = tile_k_first;
      k_last_d    = tile_k_last;
      count_d     = tile_count;
      cfg_err_d   = cfg_err;

      case (state)
         IDLE: begin
            if (start) begin
               n_rem_d     = n;
               m_rem_d     = m;
               k_rem_d     = k;
               m_cfg_d     = m;
               k_cfg_d     = k;
               lhs_step_d  = lhs_row_stride_b << LOG2S;
               rhs_step_d  = rhs_row_stride_b << LOG2S;
               dst_step_d  = dst_row_stride_b << LOG2S;
               lhs_kstep_d = cfg_16bits_ia ? (S_RW << 1) : S_RW;
               rhs_base_d  = rhs_base;
               lhs_row_d   = lhs_base;
               rhs_row_d   = rhs_base;
               dst_row_d   = dst_base;
               lhs_addr_d  = lhs_base;
               rhs_addr_d  = rhs_base;
               dst_addr_d  = dst_base;
               rows_d      = ext(n);
               cols_d      = ext(m);
               depth_d     = ext(k);
               k_first_d   = 1'b1;
               k_last_d    = (k <= S_RW);
               count_d     = '0;
               if (n == '0 || m == '0 || k == '0) begin
                  cfg_err_d = 1'b1;
                  state_d   = FINISH;
               end else begin
                  cfg_err_d = 1'b0;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (tile_ready) begin
               count_d = tile_count + RW'(1);
               if (k_end && m_end && n_end) begin
                  state_d = FINISH;
               end else if (!k_end) begin
                  k_rem_d    = k_rem - S_RW;
                  depth_d    = ext(k_rem_d);
                  k_first_d  = 1'b0;
                  k_last_d   = (k_rem_d <= S_RW);
                  lhs_addr_d = tile_lhs_addr + lhs_kstep;
                  rhs_addr_d = tile_rhs_addr + S_RW;
               end else begin
                  k_rem_d   = k_cfg;
                  depth_d   = ext(k_cfg);
                  k_first_d = 1'b1;
                  k_last_d  = (k_cfg <= S_RW);
                  if (!m_end) begin
                     m_rem_d    = m_rem - S_RW;
                     cols_d     = ext(m_rem_d);
                     rhs_row_d  = rhs_row + rhs_step;
                     rhs_addr_d = rhs_row_d;
                     lhs_addr_d = lhs_row;
                     dst_addr_d = tile_dst_addr + S_RW;
                  end else begin
                     n_rem_d    = n_rem - S_RW;
                     rows_d     = ext(n_rem_d);
                     m_rem_d    = m_cfg;
                     cols_d     = ext(m_cfg);
                     lhs_row_d  = lhs_row + lhs_step;
                     lhs_addr_d = lhs_row_d;
                     rhs_row_d  = rhs_base_q;
                     rhs_addr_d = rhs_base_q;
                     dst_row_d  = dst_row + dst_step;
                     dst_addr_d = dst_row_d;
                  end
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         n_rem         <= '0;
         m_rem         <= '0;
         k_rem         <= '0;
         m_cfg         <= '0;
         k_cfg         <= '0;
         lhs_step      <= '0;
         rhs_step      <= '0;
         dst_step      <= '0;
         lhs_kstep     <= '0;
         rhs_base_q    <= '0;
         lhs_row       <= '0;
         rhs_row       <= '0;
         dst_row       <= '0;
         tile_lhs_addr <= '0;
         tile_rhs_addr <= '0;
         tile_dst_addr <= '0;
         tile_rows     <= '0;
         tile_cols     <= '0;
         tile_depth    <= '0;
         tile_k_first  <= 1'b0;
         tile_k_last   <= 1'b0;
         tile_count    <= '0;
         cfg_err       <= 1'b0;
         tile_valid    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_d;
         n_rem         <= n_rem_d;
         m_rem         <= m_rem_d;
         k_rem         <= k_rem_d;
         m_cfg         <= m_cfg_d;
         k_cfg         <= k_cfg_d;
         lhs_step      <= lhs_step_d;
         rhs_step      <= rhs_step_d;
         dst_step      <= dst_step_d;
         lhs_kstep     <= lhs_kstep_d;
         rhs_base_q    <= rhs_base_d;
         lhs_row       <= lhs_row_d;
         rhs_row       <= rhs_row_d;
         dst_row       <= dst_row_d;
         tile_lhs_addr <= lhs_addr_d;
         tile_rhs_addr <= rhs_addr_d;
         tile_dst_addr <= dst_addr_d;
         tile_rows     <= rows_d;
         tile_cols     <= cols_d;
         tile_depth    <= depth_d;
         tile_k_first  <= k_first_d;
         tile_k_last   <= k_last_d;
         tile_count    <= count_d;
         cfg_err       <= cfg_err_d;
         tile_valid    <= (state_d == ISSUE);
         busy          <= (state_d != IDLE);
         done          <= (state_d == FINISH) && (state != FINISH);
      end
   end

endmodule
